// File: rtl/dm_pkg.sv
// Shared types and defaults for the LSU data-memory bridge.
package dm_pkg;

   typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT} dm_state_e;

   localparam logic [3:0]  WEB_NONE     = 4'b1111;
   localparam logic [31:0] DM_BASE_DEF  = 32'h0001_0000;
   localparam int          DM_DEPTH_DEF = 16384;

endpackage

// File: rtl/dm_addr_decode.sv
// Byte address to SRAM word address decode for a power-of-two memory window.
module dm_addr_decode #(
   parameter logic [31:0] BASE  = 32'h0001_0000,
   parameter int          DEPTH = 16384,
   parameter int          AW    = $clog2(DEPTH)
) (
   input  logic [31:0]   addr_i,
   output logic          in_range_o,
   output logic [AW-1:0] word_o
);

   // One extra bit so DEPTH*4 == 2^32 would still compare correctly.
   localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

   logic [31:0] off;

   assign off        = addr_i - BASE;
   assign in_range_o = ({1'b0, off} < LIMIT);
   assign word_o     = off[AW+1:2];

endmodule

// File: rtl/lsu_dm_bridge.sv
// Arbitrates committed stores and loads onto the single-port data SRAM and
// returns write acks, load words and out-of-window errors to the LSU.
module lsu_dm_bridge
   import dm_pkg::*;
#(
   parameter logic [31:0] DM_BASE  = DM_BASE_DEF,
   parameter int          DM_DEPTH = DM_DEPTH_DEF,
   parameter int          READ_LAT = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [31:0]                 ld_st_req_addr,
   input  logic                        store_req_valid,
   output logic                        store_req_ready,
   input  logic [3:0]                  store_strb,
   input  logic [31:0]                 store_data,
   output logic                        store_data_valid,
   input  logic                        load_req_valid,
   output logic                        load_req_ready,
   output logic                        load_data_valid,
   output logic [31:0]                 load_data,
   output logic                        oob_err,
   output logic                        DM_CEB,
   output logic [3:0]                  DM_WEB,
   output logic [$clog2(DM_DEPTH)-1:0] DM_A,
   output logic [31:0]                 DM_DI,
   input  logic [31:0]                 DM_DO
);

   localparam int AW = $clog2(DM_DEPTH);

   dm_state_e     state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          inr_q, inr_d;
   logic          in_range;
   logic [AW-1:0] word;
   logic          idle, st_acc, ld_acc;

   dm_addr_decode #(.BASE(DM_BASE), .DEPTH(DM_DEPTH), .AW(AW)) u_dec (
      .addr_i     (ld_st_req_addr),
      .in_range_o (in_range),
      .word_o     (word)
   );

   // Held off while rst is high so nothing is accepted or strobed during reset.
   assign idle            = (state_q == IDLE) && !rst;
   assign st_acc          = idle && store_req_valid;
   assign ld_acc          = idle && load_req_valid && !store_req_valid;
   assign store_req_ready = idle;
   assign load_req_ready  = idle && !store_req_valid;
   assign DM_A            = word;
   assign DM_DI           = store_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         inr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inr_q   <= inr_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      inr_d            = inr_q;
      DM_CEB           = 1'b1;
      DM_WEB           = WEB_NONE;
      store_data_valid = 1'b0;
      load_data_valid  = 1'b0;
      load_data        = 32'h0;
      oob_err          = 1'b0;
      case (state_q)
         IDLE: begin
            if (st_acc) begin
               state_d = WR_ACK;
               inr_d   = in_range;
               DM_CEB  = !in_range;
               DM_WEB  = in_range ? store_strb : WEB_NONE;
            end else if (ld_acc) begin
               state_d = RD_WAIT;
               cnt_d   = 2'(READ_LAT - 1);
               inr_d   = in_range;
               DM_CEB  = !in_range;
            end
         end
         WR_ACK: begin
            store_data_valid = 1'b1;
            oob_err          = !inr_q;
            state_d          = IDLE;
         end
         RD_WAIT: begin
            if (cnt_q == 2'd0) begin
               load_data_valid = 1'b1;
               load_data       = inr_q ? DM_DO : 32'h0;
               oob_err         = !inr_q;
               state_d         = IDLE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_dm_bridge.sv
// Three bridges (READ_LAT 1..3) on shared stimulus, each with its own SRAM
// model and a cycle-level transaction model of the LSU-visible behaviour.
module tb_lsu_dm_bridge;

   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam int          DEPTH = 16384;
   localparam int          AW    = $clog2(DEPTH);
   localparam int          NL    = 3;

   logic clk = 1'b0;
   logic rst;
   logic [31:0] addr, sdata;
   logic [3:0]  strb;
   logic        sv, lv;

   logic [NL-1:0]         srdy, lrdy, sdv, ldv, oob, ceb;
   logic [NL-1:0][31:0]   ld, di, dmdo;
   logic [NL-1:0][3:0]    web;
   logic [NL-1:0][AW-1:0] dma;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(int i);
      return 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
   endfunction

   for (genvar k = 0; k < NL; k++) begin : g_lane
      logic [31:0] mem [DEPTH];
      logic [31:0] pipe [3];

      initial for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);

      always @(posedge clk) begin
         if (!ceb[k]) begin
            if (web[k] == 4'hF) pipe[0] <= mem[dma[k]];
            for (int b = 0; b < 4; b++)
               if (!web[k][b]) mem[dma[k]][8*b +: 8] <= di[k][8*b +: 8];
         end
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      assign dmdo[k] = pipe[k];

      lsu_dm_bridge #(.DM_BASE(BASE), .DM_DEPTH(DEPTH), .READ_LAT(k + 1)) u_dut (
         .clk              (clk),
         .rst              (rst),
         .ld_st_req_addr   (addr),
         .store_req_valid  (sv),
         .store_req_ready  (srdy[k]),
         .store_strb       (strb),
         .store_data       (sdata),
         .store_data_valid (sdv[k]),
         .load_req_valid   (lv),
         .load_req_ready   (lrdy[k]),
         .load_data_valid  (ldv[k]),
         .load_data        (ld[k]),
         .oob_err          (oob[k]),
         .DM_CEB           (ceb[k]),
         .DM_WEB           (web[k]),
         .DM_A             (dma[k]),
         .DM_DI            (di[k]),
         .DM_DO            (dmdo[k])
      );
   end

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         if (errs <= 40) $display("FAIL %s lane%0d got=%h want=%h t=%0t", nm, k, act, exp, $time);
      end
   endtask

   // Transaction-level reference: one outstanding op per lane, completion time
   // and busy window derived directly from the latency rules.
   logic [31:0] rmem [NL][DEPTH];
   int          free_at [NL];
   int          resp_at [NL];
   bit          resp_st [NL];
   bit          resp_oob [NL];
   logic [31:0] resp_dat [NL];
   int          cyc = 0;

   always @(negedge clk) begin
      for (int k = 0; k < NL; k++) begin
         if (rst) begin
            chk("rst_srdy", k, 32'(srdy[k]), 0);
            chk("rst_lrdy", k, 32'(lrdy[k]), 0);
            chk("rst_sdv",  k, 32'(sdv[k]), 0);
            chk("rst_ldv",  k, 32'(ldv[k]), 0);
            chk("rst_ld",   k, ld[k], 0);
            chk("rst_ceb",  k, 32'(ceb[k]), 1);
            chk("rst_web",  k, 32'(web[k]), 32'hF);
            free_at[k] = 0;
            resp_at[k] = -1;
         end else begin
            bit idle, sa, la, inr, due;
            logic [31:0] off;
            int wa;
            idle = (cyc >= free_at[k]);
            sa   = idle && sv;
            la   = idle && lv && !sv;
            off  = addr - BASE;
            inr  = (off < 32'(DEPTH * 4));
            wa   = int'(off / 4);
            due  = (resp_at[k] == cyc);
            chk("srdy", k, 32'(srdy[k]), 32'(idle));
            chk("lrdy", k, 32'(lrdy[k]), 32'(idle && !sv));
            chk("ceb",  k, 32'(ceb[k]), 32'(!((sa || la) && inr)));
            chk("web",  k, 32'(web[k]), (sa && inr) ? 32'(strb) : 32'hF);
            if ((sa || la) && inr) chk("dm_a", k, 32'(dma[k]), 32'(wa));
            if (sa && inr) chk("dm_di", k, di[k], sdata);
            chk("sdv", k, 32'(sdv[k]), 32'(due && resp_st[k]));
            chk("ldv", k, 32'(ldv[k]), 32'(due && !resp_st[k]));
            chk("ld",  k, ld[k], (due && !resp_st[k]) ? resp_dat[k] : 32'h0);
            chk("oob", k, 32'(oob[k]), 32'(due && resp_oob[k]));
            if (sa) begin
               resp_at[k]  = cyc + 1;
               resp_st[k]  = 1'b1;
               resp_oob[k] = !inr;
               free_at[k]  = cyc + 2;
               if (inr)
                  for (int b = 0; b < 4; b++)
                     if (!strb[b]) rmem[k][wa][8*b +: 8] = sdata[8*b +: 8];
            end else if (la) begin
               resp_at[k]  = cyc + k + 1;
               resp_st[k]  = 1'b0;
               resp_oob[k] = !inr;
               resp_dat[k] = inr ? rmem[k][wa] : 32'h0;
               free_at[k]  = cyc + k + 2;
            end
         end
      end
      cyc++;
   end

   typedef struct {
      bit          st;
      logic [31:0] a;
      logic [3:0]  s;
      logic [31:0] d;
      bit          e_ceb;
      logic [3:0]  e_web;
      logic [31:0] e_a;
      bit          e_oob;
      logic [31:0] e_ld;
   } vec_t;

   vec_t vt [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < NL; k++)
         for (int i = 0; i < DEPTH; i++) rmem[k][i] = init_word(i);
      rst = 1'b1; sv = 1'b0; lv = 1'b0; addr = '0; strb = 4'hF; sdata = '0;

      vt[0] = '{1, 32'h0001_0010, 4'b0000, 32'hDEAD_BEEF, 0, 4'b0000, 4,       0, 0};
      vt[1] = '{0, 32'h0001_0012, 4'b1111, 32'h0,         0, 4'b1111, 4,       0, 32'hDEAD_BEEF};
      vt[2] = '{0, 32'h0000_0004, 4'b1111, 32'h0,         1, 4'b1111, 0,       1, 32'h0};
      vt[3] = '{1, 32'h0002_0000, 4'b0000, 32'h5555_AAAA, 1, 4'b1111, 0,       1, 32'h0};
      vt[4] = '{1, 32'h0001_FFFC, 4'b0101, 32'h1122_3344, 0, 4'b0101, DEPTH-1, 0, 0};
      vt[5] = '{0, 32'h0001_FFFC, 4'b1111, 32'h0,         0, 4'b1111, DEPTH-1, 0,
                (init_word(DEPTH-1) & 32'h00FF_00FF) | 32'h1100_3300};
      vt[6] = '{1, 32'h0001_0020, 4'b1111, 32'h0,         0, 4'b1111, 8,       0, 0};
      vt[7] = '{0, 32'h0001_0020, 4'b1111, 32'h0,         0, 4'b1111, 8,       0, init_word(8)};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         sv = vt[i].st; lv = !vt[i].st; addr = vt[i].a; strb = vt[i].s; sdata = vt[i].d;
         @(negedge clk);
         chk("t_ceb", i, 32'(ceb[0]), 32'(vt[i].e_ceb));
         chk("t_web", i, 32'(web[0]), 32'(vt[i].e_web));
         if (!vt[i].e_ceb) chk("t_dma", i, 32'(dma[0]), vt[i].e_a);
         if (vt[i].st && !vt[i].e_ceb) chk("t_di", i, di[0], vt[i].d);
         tick();
         sv = 1'b0; lv = 1'b0;
         @(negedge clk);
         if (vt[i].st) chk("t_sdv", i, 32'(sdv[0]), 1);
         else begin
            chk("t_ldv", i, 32'(ldv[0]), 1);
            chk("t_ld",  i, ld[0], vt[i].e_ld);
            chk("t_lrdy_busy", i, 32'(lrdy[0]), 0);
         end
         chk("t_oob", i, 32'(oob[0]), 32'(vt[i].e_oob));
         repeat (4) tick();
      end

      // Store and load together; READ_LAT=3 lane timed from the load accept.
      sv = 1'b1; lv = 1'b1; addr = BASE + 32'h40; strb = 4'b0000; sdata = 32'hCAFE_F00D;
      @(negedge clk);
      chk("sim_srdy", 2, 32'(srdy[2]), 1);
      chk("sim_lrdy", 2, 32'(lrdy[2]), 0);
      tick();
      sv = 1'b0;
      @(negedge clk);
      chk("sim_wrack", 2, 32'(sdv[2]), 1);
      chk("sim_lrdy_ack", 2, 32'(lrdy[2]), 0);
      tick();
      @(negedge clk);
      chk("sim_ld_acc", 2, 32'(lrdy[2]), 1);
      tick();
      lv = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         chk("sim_ldv", j, 32'(ldv[2]), 32'(j == 3));
         if (j == 3) chk("sim_ld", 2, ld[2], 32'hCAFE_F00D);
         tick();
      end
      repeat (4) tick();

      // Reset one cycle after a READ_LAT=2 load is accepted.
      lv = 1'b1; addr = BASE + 32'h40;
      @(negedge clk);
      chk("rmr_acc", 1, 32'(lrdy[1]), 1);
      tick();
      lv = 1'b0; rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("rmr_ldv", j, 32'(ldv[1]), 0);
         chk("rmr_ceb", j, 32'(ceb[1]), 1);
         tick();
      end

      for (int n = 0; n < 3000; n++) begin
         sv    = ($urandom_range(0, 2) == 0);
         lv    = $urandom_range(0, 1) == 1;
         addr  = ($urandom_range(0, 7) == 0) ? $urandom :
                 BASE + (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(0, 3));
         strb  = 4'($urandom);
         sdata = $urandom;
         rst   = ($urandom_range(0, 399) == 0);
         tick();
      end
      sv = 1'b0; lv = 1'b0; rst = 1'b0;
      repeat (6) tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/lsu_dm_bridge.md
Name: lsu_dm_bridge

Overview:
- Sits directly downstream of the LSU's data-memory request port and drives the single-port synchronous data SRAM (DM).
- Arbitrates between the committed-store stream and the load stream; stores win.
- Sequences SRAM chip-enable, byte write-enables, address and write data.
- Returns the write acknowledge, load-accept, and raw 32-bit load-word responses the LSU consumes. The LSU does byte/half extraction and sign extension; this block does not.

Parameters:
- DM_BASE, 32'h0001_0000, byte base address of the DM window.
- DM_DEPTH, 16384, DM size in 32-bit words; power of two.
- READ_LAT, 1, SRAM read latency in cycles from enable edge to valid DM_DO; legal 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ld_st_req_addr  in  32  byte address for the current load or store request
- store_req_valid  in  1  committed store pending
- store_req_ready  out  1  store accepted this cycle
- store_strb  in  4  per-byte active-low write mask (0 = write byte)
- store_data  in  32  lane-aligned store data
- store_data_valid  out  1  one-cycle pulse: store written
- load_req_valid  in  1  load request pending
- load_req_ready  out  1  load accepted this cycle
- load_data_valid  out  1  one-cycle pulse: load_data valid
- load_data  out  32  raw aligned word read
- oob_err  out  1  one-cycle pulse with a response whose address fell outside the DM window
- DM_CEB  out  1  SRAM chip enable, active-low
- DM_WEB  out  4  SRAM byte write enable, active-low
- DM_A  out  $clog2(DM_DEPTH)  SRAM word address
- DM_DI  out  32  SRAM write data
- DM_DO  in  32  SRAM read data

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high, and is fixed.
- States: IDLE, WR_ACK, RD_WAIT. Reset state is IDLE.
- Reset values: all valid/ready pulses 0, DM_CEB=1, DM_WEB=4'b1111, load_data=0, latency counter 0.
- Reset asserted mid-operation: any in-flight response is dropped and no pulse is emitted.
- Readiness: store_req_ready and load_req_ready may be 1 only in IDLE.
  - store_req_ready = IDLE.
  - load_req_ready = IDLE && !store_req_valid.
- Simultaneous load and store valid: the store is accepted; the load waits.
- Address decode: off = ld_st_req_addr - DM_BASE (32-bit wrap).
  - In range iff off < DM_DEPTH*4.
  - DM_A = off[$clog2(DM_DEPTH)+1:2]; address bits [1:0] are ignored.
- Store accept (cycle N):
  - In range: DM_CEB=0, DM_WEB=store_strb, DM_DI=store_data, all combinational in cycle N.
  - Out of range: DM_CEB stays 1.
  - N+1: state WR_ACK, store_data_valid=1, oob_err=!in_range. Next cycle returns to IDLE.
  - store_strb=4'b1111 is a legal no-op write and is still acknowledged.
- Load accept (cycle N):
  - In range: DM_CEB=0, DM_WEB=4'b1111.
  - Go to RD_WAIT; latency counter loads READ_LAT-1; in_range is registered.
  - load_data_valid=1 in cycle N+READ_LAT.
  - load_data = DM_DO if in range, else 32'h0; oob_err as registered.
  - Returns to IDLE in the same cycle as the valid pulse, so the earliest next accept is N+READ_LAT+1.
- Idle SRAM drive: DM_CEB=1 and DM_WEB=4'b1111 whenever no accept occurs.
- load_data = 0 when load_data_valid=0.
- Request holding: requests need not be held after accept; request fields are registered at accept where later cycles need them.
- Throughput:
  - Store: one per 2 cycles.
  - Load: one per READ_LAT+1 cycles.
- No cancellation input: a load accepted before a mispredict still completes.

Decomposition:
- Shared package (dm_pkg):
  - State enum {IDLE, WR_ACK, RD_WAIT}.
  - WEB_NONE = 4'b1111.
  - DM_BASE / DM_DEPTH defaults for the top level.
- Optional sub-module dm_addr_decode: combinational off/in_range/DM_A computation, reusable by a future IM bridge.
- All sequential logic stays in lsu_dm_bridge.

Test Plan:
1. Reset mid-read: READ_LAT=2, rst asserted one cycle after load accept -> no load_data_valid ever; DM_CEB=1, state IDLE, outputs at reset values.
2. Store word: addr 32'h0001_0010, strb 4'b0000, data 32'hDEAD_BEEF -> same cycle DM_CEB=0, DM_WEB=0000, DM_A=4, DM_DI=DEADBEEF; next cycle store_data_valid=1, oob_err=0.
3. Load after store, READ_LAT=1:
   - Stimulus: load addr 32'h0001_0012 with the SRAM model holding DEADBEEF at word 4.
   - Response: load_data_valid=1 one cycle after accept; load_data=32'hDEAD_BEEF; load_req_ready=0 in the valid cycle.
4. Simultaneous requests: load and store valid together in IDLE.
   - Store accepted, load_req_ready=0.
   - Load accepted in the cycle after WR_ACK.
   - READ_LAT=3: load_data_valid exactly 3 cycles after load accept.
5. Out-of-range accesses:
   - Load addr 32'h0000_0004 -> no DM_CEB assertion; load_data=0, load_data_valid=1, oob_err=1.
   - Store addr 32'h0001_0000+DM_DEPTH*4 -> acked, DM_CEB stays 1, oob_err=1.
6. Wrap and no-op:
   - Addr DM_BASE+DM_DEPTH*4-4 -> DM_A=DM_DEPTH-1.
   - strb 4'b1111 store -> DM_CEB=0, DM_WEB=1111, still acknowledged.
